// File: rtl/sum_display_scan_pkg.sv
// +----------------------------------------------------------------------+
// | sum_display_scan_pkg: segment patterns and digit-state type shared   |
// | by the two-digit sum display.                     Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

package sum_display_scan_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] SEL_ONES = 2'b10;
  localparam logic [1:0] SEL_TENS = 2'b01;
  localparam logic [1:0] SEL_OFF  = 2'b11;

  typedef enum logic [0:0] {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_state_e;

  // Tens digit of a 0..31 value by threshold compare.
  function automatic logic [1:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 2'd3;
    else if (v >= 5'd20) return 2'd2;
    else if (v >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sum_display_scan_seg7.sv
// +----------------------------------------------------------------------+
// | seg7_decode: BCD digit to active-low seven-segment pattern; codes    |
// | 10..15 are blank.                                 Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_decode
  import sum_display_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sum_display_scan.sv
// +----------------------------------------------------------------------+
// | sum_display_scan: holds a 5-bit adder result and time-multiplexes it |
// | onto a two-digit common-anode display.            Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module sum_display_scan
  import sum_display_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       load_in,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  output logic [6:0] seg_out,
  output logic [1:0] dig_sel_out,
  output logic [4:0] value_out
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [4:0]  value_q, value_d;
  logic [15:0] cnt_q, cnt_d;
  dig_state_e  dig_q, dig_d;
  logic [6:0]  seg_q;
  logic [1:0]  sel_q, sel_d;

  logic [1:0]  tens;
  logic [3:0]  ones;
  logic [3:0]  dec_digit;
  logic [6:0]  dec_seg;

  seg7_decode u_dec (
    .digit_i (dec_digit),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      value_q <= 5'd0;
      cnt_q   <= 16'd0;
      dig_q   <= DIG_ONES;
      seg_q   <= SEG_BLANK;
      sel_q   <= SEL_OFF;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      seg_q   <= dec_seg;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    value_d   = load_in ? {carry_in, sum_in} : value_q;
    cnt_d     = cnt_q + 16'd1;
    dig_d     = dig_q;
    sel_d     = SEL_ONES;
    tens      = tens_of(value_q);
    // Ones = value - 10*tens evaluated mod 16; the true result is < 10.
    ones      = value_q[3:0] - (4'd10 * {2'b00, tens});
    dec_digit = ones;

    if (cnt_q == CNT_MAX) begin
      cnt_d = 16'd0;
      dig_d = (dig_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end

    if (dig_q == DIG_TENS) begin
      sel_d     = SEL_TENS;
      dec_digit = (tens == 2'd0) ? 4'hF : {2'b00, tens};
    end
  end

  assign value_out   = value_q;
  assign seg_out     = seg_q;
  assign dig_sel_out = sel_q;

endmodule

`default_nettype wire

// File: doc/sum_display_scan.md
SUM_DISPLAY_SCAN -- requirements
Module: sum_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is displayed; legal range 2..65535.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port load_in  input  1  capture strobe; when high at a rising edge, sum_in/carry_in are captured.
REQ-005 SHALL have port sum_in  input  4  4-bit sum from the upstream 4-bit adder.
REQ-006 SHALL have port carry_in  input  1  carry out from the upstream 4-bit adder; weight 16.
REQ-007 SHALL have port seg_out  output  7  segments {g,f,e,d,c,b,a}, bit0=a, active-low (common anode).
REQ-008 SHALL have port dig_sel_out  output  2  digit enables, bit0=ones, bit1=tens, active-low, at most one low.
REQ-009 SHALL have port value_out  output  5  currently held result {carry,sum}, 0..31.

Function
REQ-010 SHALL hold a 5-bit value register loaded with {carry_in,sum_in} at each rising edge where load_in=1; otherwise unchanged.
REQ-011 SHALL drive value_out directly from the value register (visible the same edge it loads).
REQ-012 SHALL split value into tens = 3/2/1/0 for value >=30/>=20/>=10/else, ones = value - 10*tens; no divider.
REQ-013 SHALL run a scan counter 0..SCAN_DIV-1, wrapping to 0; on wrap, digit state toggles.
REQ-014 SHALL implement digit FSM with states DIG_ONES and DIG_TENS; DIG_ONES -> DIG_TENS -> DIG_ONES only on counter wrap.
REQ-015 SHALL register seg_out and dig_sel_out: at each edge they take the pattern for the current digit state and value register as they were before that edge (one-cycle output latency).
REQ-016 SHALL, in DIG_ONES, drive dig_sel_out=2'b10 and seg_out=pattern(ones).
REQ-017 SHALL, in DIG_TENS with tens=0, blank leading zero: seg_out=7'h7F, dig_sel_out=2'b01.
REQ-018 SHALL, in DIG_TENS with tens!=0, drive dig_sel_out=2'b01 and seg_out=pattern(tens).
REQ-019 SHALL use patterns (active-low, {g..a}): 0=7'h40,1=7'h79,2=7'h24,3=7'h30,4=7'h19,5=7'h12,6=7'h02,7=7'h78,8=7'h00,9=7'h10.
REQ-020 SHALL NOT reset or stall the scan counter or digit FSM on load_in; a load mid-scan only changes the displayed pattern (after REQ-015 latency).
REQ-021 SHALL treat load_in held high across consecutive edges as a load on every such edge.

Reset
REQ-022 SHALL, while rst_n_in=0, force value register=0, scan counter=0, digit state=DIG_ONES, seg_out=7'h7F, dig_sel_out=2'b11, value_out=0.
REQ-023 SHALL, at the first rising edge after release, output dig_sel_out=2'b10, seg_out=7'h40 (ones "0").
REQ-024 SHALL abandon any scan in progress when reset asserts mid-operation, with no output glitch beyond the REQ-022 values.

Structure
REQ-025 SHALL place in shared package: segment pattern constants SEG_0..SEG_9, SEG_BLANK=7'h7F, digit-state typedef {DIG_ONES,DIG_TENS}.
REQ-026 SHALL use one combinational sub-module seg7_decode (4-bit digit in, 7-bit active-low pattern out); codes 10..15 map to SEG_BLANK.
REQ-027 SHALL sit directly downstream of the 4-bit adder, connecting its sum and carry outputs to sum_in/carry_in.

Verification (SCAN_DIV=4 in bench)
REQ-028 SHALL check reset: rst_n_in=0 -> seg_out=7'h7F, dig_sel_out=2'b11, value_out=0; release -> next edge dig_sel_out=2'b10, seg_out=7'h40.
REQ-029 SHALL check load 1+0xF: load_in=1, carry_in=1, sum_in=4'hF -> value_out=31; ones phase seg_out=7'h79 ("1"), tens phase seg_out=7'h30 ("3").
REQ-030 SHALL check blanking: load value 7 -> ones seg_out=7'h78, tens phase seg_out=7'h7F with dig_sel_out=2'b01.
REQ-031 SHALL check scan timing: digit changes exactly every 4 cycles, dig_sel_out alternates 2'b10/2'b01, never 2'b00.
REQ-032 SHALL check mid-scan load: load 10 at counter=2 in DIG_TENS -> seg_out=7'h79 one edge later, digit switch still at counter wrap.
REQ-033 SHALL check async reset mid-scan: assert rst_n_in between edges -> outputs immediately reach REQ-022 values without a clock edge.
